// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serial memory port controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {W_BYTE = 2'b00, W_HALF = 2'b01, W_WORD = 2'b10} width_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;
  localparam logic [1:0] IO_REGION_DEF = 2'b11;
  function automatic logic [2:0] width_len(input logic [1:0] w);
    return w == W_BYTE ? 3'd1 : w == W_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store onto the byte-wide RAM/IO port,
// moving each access as little-endian byte transfers and pulsing valid once done
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_REGION = IO_REGION_DEF
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        ifFlagIn,
  input  logic [31:0] ifAddrIn,
  output logic        ifValidOut,
  output logic [31:0] ifDataOut,
  input  logic        lsFlagIn,
  input  logic        lsWriteIn,
  input  logic [1:0]  lsWidthIn,
  input  logic [31:0] lsAddrIn,
  input  logic [31:0] lsDataIn,
  output logic        lsValidOut,
  output logic [31:0] lsDataOut,
  input  logic [7:0]  memDataIn,
  output logic [7:0]  memDataOut,
  output logic [31:0] memAddrOut,
  output logic        memWrOut,
  input  logic        ioFullIn
);
  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d, len_q, len_d;
  logic        issued_q, issued_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [31:0] ifdata_q, ifdata_d, lsdata_q, lsdata_d;
  logic [31:0] asm_w;
  logic [1:0]  lane;
  logic        ls_go, stall;

  // a flushed load must not be accepted in the same cycle as the flush
  assign ls_go = lsFlagIn && !(clearIn && !lsWriteIn);
  assign stall = ioFullIn && addr_q[17:16] == IO_REGION;
  assign lane = cnt_q[1:0] - 2'd1;
  assign ifValidOut = state_q == S_DONE && readyIn && owner_q == OWN_IF;
  assign lsValidOut = state_q == S_DONE && readyIn && owner_q == OWN_LS;
  assign ifDataOut = ifdata_q;
  assign lsDataOut = lsdata_q;

  // the byte issued last cycle lands in its lane now, independent of readyIn
  always_comb begin
    asm_w = rbuf_q;
    if (issued_q) asm_w[{lane, 3'b000} +: 8] = memDataIn;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    len_d = len_q;
    issued_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rbuf_d = asm_w;
    ifdata_d = ifdata_q;
    lsdata_d = lsdata_q;
    memWrOut = 1'b0;
    memAddrOut = '0;
    memDataOut = '0;
    case (state_q)
      S_IDLE: if (readyIn && (ls_go || ifFlagIn)) begin
        owner_d = ls_go ? OWN_LS : OWN_IF;
        addr_d = ls_go ? lsAddrIn : ifAddrIn;
        len_d = ls_go ? width_len(lsWidthIn) : 3'd4;
        wdata_d = lsDataIn;
        cnt_d = '0;
        rbuf_d = '0;
        state_d = ls_go && lsWriteIn ? S_WRITE : S_READ;
      end
      S_READ: begin
        memAddrOut = cnt_q < len_q ? addr_q + 32'(cnt_q) : '0;
        if (clearIn && owner_q == OWN_LS) state_d = S_IDLE;
        else if (readyIn && cnt_q < len_q) begin
          issued_d = 1'b1;
          cnt_d = cnt_q + 3'd1;
        end else if (readyIn) begin
          state_d = S_DONE;
          ifdata_d = owner_q == OWN_IF ? asm_w : ifdata_q;
          lsdata_d = owner_q == OWN_LS ? asm_w : lsdata_q;
        end
      end
      S_WRITE: begin
        memAddrOut = addr_q + 32'(cnt_q);
        memDataOut = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (readyIn && !stall) begin
          memWrOut = 1'b1;
          cnt_d = cnt_q + 3'd1;
          state_d = cnt_q + 3'd1 == len_q ? S_DONE : S_WRITE;
        end
      end
      S_DONE: state_d = readyIn ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      cnt_q <= '0;
      len_q <= '0;
      issued_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rbuf_q <= '0;
      ifdata_q <= '0;
      lsdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      issued_q <= issued_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q <= rbuf_d;
      ifdata_q <= ifdata_d;
      lsdata_q <= lsdata_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, corner-case sequences and random traffic against a byte-array model
module tb_mem_ctrl;
  logic        clockIn = 0, resetIn = 1, readyIn = 1, clearIn = 0;
  logic        ifFlagIn = 0, lsFlagIn = 0, lsWriteIn = 0, ioFullIn = 0;
  logic [1:0]  lsWidthIn = 0;
  logic [31:0] ifAddrIn = 0, lsAddrIn = 0, lsDataIn = 0;
  logic [7:0]  memDataIn = 0;
  logic        ifValidOut, lsValidOut, memWrOut;
  logic [31:0] ifDataOut, lsDataOut, memAddrOut;
  logic [7:0]  memDataOut;
  int checks = 0, errors = 0;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];
  logic [39:0] wlog [$];

  typedef struct {
    bit ls;
    bit wr;
    logic [1:0] w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int lat;
  } vec_t;
  vec_t tbl [11];

  mem_ctrl dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .ifFlagIn(ifFlagIn), .ifAddrIn(ifAddrIn), .ifValidOut(ifValidOut), .ifDataOut(ifDataOut),
    .lsFlagIn(lsFlagIn), .lsWriteIn(lsWriteIn), .lsWidthIn(lsWidthIn), .lsAddrIn(lsAddrIn),
    .lsDataIn(lsDataIn), .lsValidOut(lsValidOut), .lsDataOut(lsDataOut),
    .memDataIn(memDataIn), .memDataOut(memDataOut), .memAddrOut(memAddrOut),
    .memWrOut(memWrOut), .ioFullIn(ioFullIn)
  );

  always #5 clockIn = ~clockIn;

  // RAM: read data reflects the previous cycle's address; writes are logged
  always @(posedge clockIn) begin
    memDataIn <= ram.exists(memAddrOut) ? ram[memAddrOut] : 8'h00;
    if (memWrOut) begin
      ram[memAddrOut] = memDataOut;
      wlog.push_back({memAddrOut, memDataOut});
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] w);
    return w == 2'b00 ? 1 : w == 2'b01 ? 2 : 4;
  endfunction

  task automatic step;
    @(posedge clockIn);
    #1;
  endtask

  // lat counts cycles from the request cycle (0) to the valid cycle; -1 on timeout
  task automatic req(input bit ls, input bit wr, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] d, input int tmo, output int lat, output logic [31:0] q);
    lat = -1;
    q = '0;
    if (ls) begin
      lsFlagIn = 1; lsWriteIn = wr; lsWidthIn = w; lsAddrIn = a; lsDataIn = d;
    end else begin
      ifFlagIn = 1; ifAddrIn = a;
    end
    for (int c = 0; c < tmo && lat < 0; c++) begin
      @(negedge clockIn);
      check("stray_valid", ls ? ifValidOut : lsValidOut, 0);
      if (ls ? lsValidOut : ifValidOut) begin
        lat = c;
        q = ls ? lsDataOut : ifDataOut;
      end
      step();
    end
    lsFlagIn = 0;
    ifFlagIn = 0;
  endtask

  task automatic xact(input string nm, input bit ls, input bit wr, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    int n, lat;
    logic [31:0] q, e;
    n = ls ? nb(w) : 4;
    e = '0;
    for (int k = 0; k < n; k++) e |= 32'(mdl.exists(a + k) ? mdl[a + k] : 8'h00) << (8 * k);
    wlog.delete();
    req(ls, wr, w, a, d, 30, lat, q);
    check({nm, "_lat"}, lat, (ls && wr) ? n + 1 : n + 2);
    if (ls && wr) begin
      check({nm, "_nwr"}, wlog.size(), n);
      for (int k = 0; k < n && k < wlog.size(); k++) begin
        check({nm, "_wr"}, wlog[k], {a + k, d[8 * k +: 8]});
        mdl[a + k] = d[8 * k +: 8];
      end
    end else check({nm, "_data"}, q, e);
  endtask

  initial begin
    int lat, ls_at, if_at, vcount;
    logic [31:0] q, lsq, ifq, a;
    logic [31:0] pa [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h20};
    logic [7:0]  pd [5] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hAB};
    for (int i = 0; i < 5; i++) begin
      ram[pa[i]] = pd[i];
      mdl[pa[i]] = pd[i];
    end
    tbl[0]  = '{0, 0, 2'b10, 32'h100, 32'h0, 32'h00100513, 6};
    tbl[1]  = '{1, 0, 2'b00, 32'h20,  32'h0, 32'h000000AB, 3};
    tbl[2]  = '{1, 0, 2'b01, 32'h100, 32'h0, 32'h00000513, 4};
    tbl[3]  = '{1, 0, 2'b00, 32'h102, 32'h0, 32'h00000010, 3};
    tbl[4]  = '{1, 1, 2'b10, 32'h200, 32'hDEADBEEF, 32'h0, 5};
    tbl[5]  = '{1, 0, 2'b10, 32'h200, 32'h0, 32'hDEADBEEF, 6};
    tbl[6]  = '{1, 1, 2'b00, 32'h201, 32'hFFFFFF77, 32'h0, 2};
    tbl[7]  = '{1, 0, 2'b01, 32'h200, 32'h0, 32'h000077EF, 4};
    tbl[8]  = '{1, 0, 2'b11, 32'h200, 32'h0, 32'hDEAD77EF, 6};
    tbl[9]  = '{1, 1, 2'b01, 32'h202, 32'hAAAA1234, 32'h0, 3};
    tbl[10] = '{0, 0, 2'b10, 32'h200, 32'h0, 32'h123477EF, 6};

    repeat (3) step();
    @(negedge clockIn);
    check("rst_ifv", ifValidOut, 0);
    check("rst_lsv", lsValidOut, 0);
    check("rst_wr", memWrOut, 0);
    check("rst_addr", memAddrOut, 0);
    check("rst_wd", memDataOut, 0);
    check("rst_ifd", ifDataOut, 0);
    check("rst_lsd", lsDataOut, 0);
    resetIn = 0;
    step();

    for (int i = 0; i < 11; i++) begin
      req(tbl[i].ls, tbl[i].wr, tbl[i].w, tbl[i].a, tbl[i].d, 30, lat, q);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      if (!tbl[i].wr) check($sformatf("vec%0d_data", i), q, tbl[i].exp);
      else for (int k = 0; k < nb(tbl[i].w); k++) begin
        a = tbl[i].d;
        mdl[tbl[i].a + k] = a[8 * k +: 8];
      end
    end

    // LS and IF together: LS byte load first, IF accepted the cycle after LS DONE
    lsFlagIn = 1; lsWriteIn = 0; lsWidthIn = 2'b00; lsAddrIn = 32'h20;
    ifFlagIn = 1; ifAddrIn = 32'h100;
    ls_at = -1; if_at = -1; lsq = 0; ifq = 0;
    for (int c = 0; c < 30 && if_at < 0; c++) begin
      @(negedge clockIn);
      if (c == 1) check("arb_ls_addr", memAddrOut, 32'h20);
      if (c >= 5 && c <= 8) check($sformatf("arb_if_addr%0d", c - 5), memAddrOut, 32'h100 + c - 5);
      if (lsValidOut && ls_at < 0) begin ls_at = c; lsq = lsDataOut; end
      if (ifValidOut) begin if_at = c; ifq = ifDataOut; end
      step();
      if (ls_at >= 0) lsFlagIn = 0;
    end
    ifFlagIn = 0;
    check("arb_ls_lat", ls_at, 3);
    check("arb_ls_data", lsq, 32'h000000AB);
    check("arb_if_lat", if_at, 10);
    check("arb_if_data", ifq, 32'h00100513);

    // IO-region half store with the IO buffer full for the first 3 WRITE cycles
    fork
      begin ioFullIn = 1; repeat (4) step(); ioFullIn = 0; end
      begin wlog.delete(); req(1, 1, 2'b01, 32'h30000, 32'h00001234, 30, lat, q); end
    join
    check("io_lat", lat, 6);
    check("io_nwr", wlog.size(), 2);
    check("io_wr0", wlog.size() > 0 ? wlog[0] : 40'h0, {32'h30000, 8'h34});
    check("io_wr1", wlog.size() > 1 ? wlog[1] : 40'h0, {32'h30001, 8'h12});
    mdl[32'h30000] = 8'h34;
    mdl[32'h30001] = 8'h12;

    // readyIn low for two cycles after the first byte of a word fetch
    fork
      begin repeat (2) step(); readyIn = 0; repeat (2) step(); readyIn = 1; end
      req(0, 0, 2'b10, 32'h100, 32'h0, 30, lat, q);
    join
    check("rdy_lat", lat, 8);
    check("rdy_data", q, 32'h00100513);

    // flush a word load after two bytes were issued
    lsFlagIn = 1; lsWriteIn = 0; lsWidthIn = 2'b10; lsAddrIn = 32'h100;
    repeat (3) step();
    clearIn = 1; lsFlagIn = 0; vcount = 0;
    @(negedge clockIn);
    vcount += int'(lsValidOut);
    step();
    clearIn = 0;
    @(negedge clockIn);
    check("clr_idle_addr", memAddrOut, 0);
    step();
    for (int c = 0; c < 8; c++) begin
      @(negedge clockIn);
      vcount += int'(lsValidOut);
      step();
    end
    check("clr_no_valid", vcount, 0);
    xact("clr_if", 0, 0, 2'b10, 32'h100, 32'h0);

    // reset while byte 1 of a word store is on the bus
    lsFlagIn = 1; lsWriteIn = 1; lsWidthIn = 2'b10; lsAddrIn = 32'h400; lsDataIn = 32'h12345678;
    step();
    step();
    @(negedge clockIn);
    check("rstw_b1_wr", memWrOut, 1);
    check("rstw_b1_addr", memAddrOut, 32'h401);
    resetIn = 1;
    step();
    resetIn = 0; lsFlagIn = 0;
    @(negedge clockIn);
    check("rstw_wr", memWrOut, 0);
    check("rstw_addr", memAddrOut, 0);
    check("rstw_wd", memDataOut, 0);
    check("rstw_ifd", ifDataOut, 0);
    check("rstw_lsd", lsDataOut, 0);
    vcount = 0;
    step();
    for (int c = 0; c < 8; c++) begin
      @(negedge clockIn);
      vcount += int'(lsValidOut) + int'(ifValidOut);
      step();
    end
    check("rstw_no_valid", vcount, 0);

    for (int i = 0; i < 60; i++) begin
      bit ls, wr;
      ls = $urandom_range(0, 3) != 0;
      wr = ls && $urandom_range(0, 1) == 1;
      xact($sformatf("rnd%0d", i), ls, wr, 2'($urandom_range(0, 3)),
           32'h1000 + $urandom_range(0, 31), $urandom);
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the byte-wide unified RAM/IO port.
- Arbitrates between two requesters:
  - instruction-fetch: ICache miss path, 32-bit word reads only;
  - load/store: byte/half/word reads and writes.
- Sequences each access as little-endian byte transfers.
- Returns a one-cycle valid pulse with the assembled data.

Parameters:
- IO_REGION, 2'b11, value of address bits [17:16] that selects memory-mapped IO.

Ports:
- clockIn  in  1  clock
- resetIn  in  1  synchronous active-high reset
- readyIn  in  1  global enable; low = no new byte issued, no state change
- clearIn  in  1  pipeline flush; aborts an in-flight load
- ifFlagIn  in  1  fetch request, level, held until ifValidOut
- ifAddrIn  in  32  fetch word address
- ifValidOut  out  1  fetch done, one-cycle pulse
- ifDataOut  out  32  fetched word
- lsFlagIn  in  1  load/store request, level, held until lsValidOut
- lsWriteIn  in  1  1 = store, 0 = load
- lsWidthIn  in  2  00 byte, 01 half, 10 word (11 treated as word)
- lsAddrIn  in  32  byte address
- lsDataIn  in  32  store data, low bytes used
- lsValidOut  out  1  load/store done, one-cycle pulse
- lsDataOut  out  32  load data, zero-extended
- memDataIn  in  8  RAM read byte; reflects the address driven in the previous cycle
- memDataOut  out  8  RAM write byte
- memAddrOut  out  32  RAM byte address
- memWrOut  out  1  1 = write this cycle
- ioFullIn  in  1  IO buffer full

Behaviour:
- Clock and reset: one clock (clockIn); reset (resetIn) is synchronous and active-high.
- Reset values: state IDLE; all valid outputs, memWrOut, memAddrOut, memDataOut, ifDataOut and lsDataOut = 0; byte counter and issued flag = 0.
- States:
  - IDLE: accept a request.
  - READ: issue read bytes.
  - WRITE: issue write bytes.
  - DONE: valid pulse cycle.
- IDLE, readyIn=1:
  - lsFlagIn has priority over ifFlagIn.
  - Latch address, length N (1/2/4; fetch always 4), store data and owner.
  - Go to READ or WRITE.
- IDLE with no request: memWrOut=0, memAddrOut=0.
- READ:
  - Cycle k drives memAddrOut = base+k.
  - The issued flag registers that byte k was issued.
  - Next cycle captures memDataIn into byte lane k.
  - After byte N-1 is issued, wait one cycle for its capture, then go to DONE with data registered.
  - Capture always follows an issue, even if readyIn drops.
- WRITE:
  - Cycle k drives memAddrOut = base+k, memDataOut = data[8k+7:8k], memWrOut=1.
  - After byte N-1, go to DONE.
- IO stall: in WRITE, if ioFullIn=1 and base[17:16]==IO_REGION, hold the current byte with memWrOut=0 and do not advance.
- readyIn=0 in any state: memWrOut=0, counter held, no new byte issued, no transition.
- DONE:
  - Owner's valid=1 for exactly one cycle, data stable.
  - No request is accepted in DONE, because the requester's flag is still high this cycle.
  - Next state IDLE.
- Latency, counted from accept edge E0:
  - Read of N bytes: valid high in cycle E0+N+2 (word = 6, byte = 3).
  - Write of N bytes: valid high in cycle E0+N+1.
  - Each stall cycle adds one.
- clearIn, any readyIn:
  - Load owner in READ: return to IDLE next cycle, no lsValidOut, captured data discarded.
  - Fetch and store operations complete normally.
  - clearIn in IDLE blocks acceptance of a load request that cycle.
  - In DONE the pulse still occurs.
- Unused upper lanes of lsDataOut = 0.
- ifDataOut and lsDataOut are updated only when entering DONE.
- Simultaneous requests: LS served first; IF waits, its flag held.
- Reset mid-access: abort immediately, no valid, memWrOut=0 in the following cycle.

Decomposition:
- Shared package holds:
  - width encodings (BYTE/HALF/WORD);
  - state encoding (IDLE/READ/WRITE/DONE);
  - owner encoding;
  - IO_REGION default.
- No sub-module; byte-lane assembly is an indexed register write inside the block.

Test Plan:
- IF word read at 0x00000100, RAM bytes 0x13,0x05,0x10,0x00 -> addresses 0x100..0x103 on successive cycles; ifValidOut 6 cycles after accept with ifDataOut=0x00100513.
- LS and IF requested in the same IDLE cycle, LS byte load at 0x20 (RAM 0xAB) -> LS served first, lsDataOut=0x000000AB; IF starts on the cycle after LS DONE.
- LS half store 0x1234 at 0x30000 with ioFullIn high 3 cycles -> memWrOut=0 for 3 cycles, then writes 0x34@0x30000 and 0x12@0x30001; lsValidOut once.
- readyIn low for 2 cycles mid word read -> pending byte still captured; issue resumes without skipping or duplicating; data correct; valid delayed 2 cycles.
- clearIn during LS word load after 2 bytes -> IDLE next cycle; no lsValidOut; a following IF request accepted normally.
- resetIn during WRITE of byte 1 -> memWrOut=0 next cycle; all outputs at reset values; no valid pulse.
